// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect controller: decodes per-boundary stall from stage requests,
// sequences exception/ERTN redirects through a one-cycle flush, and watches for stuck stalls.
module pipe_ctrl #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallreq_fs,
    input  logic        stallreq_ds,
    input  logic        stallreq_es,
    input  logic        stallreq_ms,
    input  logic        excp_req,
    input  logic [31:0] excp_entry,
    input  logic        ertn_req,
    input  logic [31:0] era,
    output logic [5:0]  stall,
    output logic        flush,
    output logic        new_pc_valid,
    output logic [31:0] new_pc,
    output logic        stall_timeout,
    output logic [31:0] stall_cycles
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_PEND  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [15:0] RUN_LIMIT = 16'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [31:0] target_q, target_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] run_cnt_q, run_cnt_d;
    logic        timeout_q, timeout_d;
    logic [5:0]  stall_req;

    // NOTE: every signal written in an always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        stall_req = 6'b000000;
        if (stallreq_ms)      stall_req = 6'b011111;
        else if (stallreq_es) stall_req = 6'b001111;
        else if (stallreq_ds) stall_req = 6'b000111;
        else if (stallreq_fs) stall_req = 6'b000011;
    end

    // The flush pulse is masked during reset so a redirect caught mid-reset never escapes.
    assign flush        = (state_q == ST_FLUSH) && !reset;
    assign new_pc_valid = flush;
    assign new_pc       = target_q;
    assign stall        = flush ? 6'b000000 : stall_req;

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        case (state_q)
            ST_RUN: begin
                if (excp_req || ertn_req) begin
                    target_d = excp_req ? excp_entry : era;
                    state_d  = stallreq_ms ? ST_PEND : ST_FLUSH;
                end
            end
            ST_PEND: begin
                if (!stallreq_ms) state_d = ST_FLUSH;
            end
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        run_cnt_d      = 16'd0;
        timeout_d      = timeout_q;
        if (stall[0]) begin
            if (stall_cycles_q != 32'hFFFF_FFFF) stall_cycles_d = stall_cycles_q + 32'd1;
            run_cnt_d = (run_cnt_q == 16'hFFFF) ? run_cnt_q : run_cnt_q + 16'd1;
            if (run_cnt_q == RUN_LIMIT) timeout_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together
    // from pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_RUN;
            target_q       <= 32'd0;
            stall_cycles_q <= 32'd0;
            run_cnt_q      <= 16'd0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            target_q       <= target_d;
            stall_cycles_q <= stall_cycles_d;
            run_cnt_q      <= run_cnt_d;
            timeout_q      <= timeout_d;
        end
    end

    assign stall_timeout = timeout_q;
    assign stall_cycles  = stall_cycles_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a per-cycle reference model compared at every
// falling edge, plus directed scenarios with hand-computed literal expectations.
module tb_pipe_ctrl;

    localparam int TB_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        stallreq_fs, stallreq_ds, stallreq_es, stallreq_ms;
    logic        excp_req, ertn_req;
    logic [31:0] excp_entry, era;
    logic [5:0]  stall;
    logic        flush, new_pc_valid, stall_timeout;
    logic [31:0] new_pc, stall_cycles;

    int checks   = 0;
    int failures = 0;

    pipe_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk           (clk),
        .reset         (reset),
        .stallreq_fs   (stallreq_fs),
        .stallreq_ds   (stallreq_ds),
        .stallreq_es   (stallreq_es),
        .stallreq_ms   (stallreq_ms),
        .excp_req      (excp_req),
        .excp_entry    (excp_entry),
        .ertn_req      (ertn_req),
        .era           (era),
        .stall         (stall),
        .flush         (flush),
        .new_pc_valid  (new_pc_valid),
        .new_pc        (new_pc),
        .stall_timeout (stall_timeout),
        .stall_cycles  (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // Reference model: redirect bookkeeping as two flags, counters as plain integers.
    bit          m_redirect_now = 1'b0;
    bit          m_waiting      = 1'b0;
    bit          m_timeout      = 1'b0;
    logic [31:0] m_target       = 32'd0;
    longint      m_cycles       = 0;
    int          m_run          = 0;

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            begin
                int          depth;
                logic        exp_flush;
                logic [5:0]  exp_stall;
                logic [31:0] exp_cycles;
                depth = stallreq_ms ? 5 : stallreq_es ? 4 : stallreq_ds ? 3 : stallreq_fs ? 2 : 0;
                exp_flush  = m_redirect_now && !reset;
                exp_stall  = exp_flush ? 6'd0 : 6'((32'd1 << depth) - 32'd1);
                exp_cycles = (m_cycles > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(m_cycles);

                check("model_stall",        {26'd0, stall},         {26'd0, exp_stall});
                check("model_flush",        {31'd0, flush},         {31'd0, exp_flush});
                check("model_new_pc_valid", {31'd0, new_pc_valid},  {31'd0, exp_flush});
                check("model_new_pc",       new_pc,                 m_target);
                check("model_stall_cycles", stall_cycles,           exp_cycles);
                check("model_timeout",      {31'd0, stall_timeout}, {31'd0, m_timeout});

                if (reset) begin
                    m_redirect_now = 1'b0;
                    m_waiting      = 1'b0;
                    m_timeout      = 1'b0;
                    m_target       = 32'd0;
                    m_cycles       = 0;
                    m_run          = 0;
                end else begin
                    if (exp_stall[0]) begin
                        m_cycles++;
                        m_run++;
                        if (m_run >= TB_TIMEOUT) m_timeout = 1'b1;
                    end else begin
                        m_run = 0;
                    end
                    if (m_redirect_now) begin
                        m_redirect_now = 1'b0;
                    end else if (m_waiting) begin
                        if (!stallreq_ms) begin
                            m_waiting      = 1'b0;
                            m_redirect_now = 1'b1;
                        end
                    end else if (excp_req || ertn_req) begin
                        m_target = excp_req ? excp_entry : era;
                        if (stallreq_ms) m_waiting = 1'b1;
                        else m_redirect_now = 1'b1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        {stallreq_fs, stallreq_ds, stallreq_es, stallreq_ms, excp_req, ertn_req} = '0;
        excp_entry = 32'd0;
        era        = 32'd0;
        tick();
        tick();

        // Stall decode stays live during reset; counters must not move.
        stallreq_fs = 1'b1;
        @(negedge clk);
        check("rst_stall_comb", {26'd0, stall}, 32'h03);
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_new_pc", new_pc, 32'd0);
        tick();
        @(negedge clk);
        check("rst_no_count", stall_cycles, 32'd0);
        check("rst_timeout", {31'd0, stall_timeout}, 32'd0);
        tick();
        reset = 1'b0;
        stallreq_fs = 1'b0;

        // Decode + execute stall together: deepest wins; 3-cycle burst, no timeout.
        stallreq_ds = 1'b1;
        stallreq_es = 1'b1;
        @(negedge clk);
        check("ds_es_stall", {26'd0, stall}, 32'h0F);
        tick();
        @(negedge clk);
        check("ds_es_count1", stall_cycles, 32'd1);
        tick();
        tick();
        stallreq_ds = 1'b0;
        stallreq_es = 1'b0;
        @(negedge clk);
        check("ds_es_count3", stall_cycles, 32'd3);
        check("burst3_no_timeout", {31'd0, stall_timeout}, 32'd0);
        tick();

        // Exception without memory stall: flush the very next cycle.
        excp_req   = 1'b1;
        excp_entry = 32'h1C00_8000;
        @(negedge clk);
        check("excp_n_flush", {31'd0, flush}, 32'd0);
        tick();
        stallreq_es = 1'b1;
        @(negedge clk);
        check("excp_n1_flush", {31'd0, flush}, 32'd1);
        check("excp_n1_valid", {31'd0, new_pc_valid}, 32'd1);
        check("excp_n1_new_pc", new_pc, 32'h1C00_8000);
        check("excp_n1_stall_forced0", {26'd0, stall}, 32'd0);
        tick();
        excp_req = 1'b0;
        @(negedge clk);
        check("excp_n2_flush", {31'd0, flush}, 32'd0);
        check("excp_n2_stall", {26'd0, stall}, 32'h0F);
        tick();
        stallreq_es = 1'b0;
        @(negedge clk);
        check("excp_n3_flush", {31'd0, flush}, 32'd0);
        check("excp_n3_count", stall_cycles, 32'd4);
        tick();

        // ERTN under a memory stall: wait in PEND, ignore a later exception.
        ertn_req    = 1'b1;
        era         = 32'h1C00_0100;
        stallreq_ms = 1'b1;
        @(negedge clk);
        check("ertn_m0_stall", {26'd0, stall}, 32'h1F);
        tick();
        ertn_req   = 1'b0;
        excp_req   = 1'b1;
        excp_entry = 32'hDEAD_0000;
        @(negedge clk);
        check("ertn_m1_flush", {31'd0, flush}, 32'd0);
        tick();
        excp_req = 1'b0;
        @(negedge clk);
        check("ertn_m2_flush", {31'd0, flush}, 32'd0);
        tick();
        stallreq_ms = 1'b0;
        @(negedge clk);
        check("ertn_m3_flush", {31'd0, flush}, 32'd0);
        tick();
        @(negedge clk);
        check("ertn_m4_flush", {31'd0, flush}, 32'd1);
        check("ertn_m4_new_pc", new_pc, 32'h1C00_0100);
        tick();
        @(negedge clk);
        check("ertn_m5_flush", {31'd0, flush}, 32'd0);
        check("ertn_m5_new_pc_hold", new_pc, 32'h1C00_0100);
        check("ms3_no_timeout", {31'd0, stall_timeout}, 32'd0);
        tick();

        // Exception and ERTN together: exception entry wins.
        excp_req   = 1'b1;
        ertn_req   = 1'b1;
        excp_entry = 32'h1C00_8040;
        era        = 32'h1C00_0200;
        tick();
        excp_req = 1'b0;
        ertn_req = 1'b0;
        @(negedge clk);
        check("both_flush", {31'd0, flush}, 32'd1);
        check("both_new_pc", new_pc, 32'h1C00_8040);
        tick();

        // Reset landing on the flush cycle suppresses the pulse.
        excp_req   = 1'b1;
        excp_entry = 32'h1C00_80C0;
        tick();
        excp_req = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        check("rst_in_flush_masked", {31'd0, flush}, 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_flush_after", {31'd0, flush}, 32'd0);
        check("rst_flush_new_pc", new_pc, 32'd0);
        tick();

        // Reset while PEND: redirect discarded.
        ertn_req    = 1'b1;
        era         = 32'h1C00_0300;
        stallreq_ms = 1'b1;
        tick();
        ertn_req = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        check("rst_pend_stall_comb", {26'd0, stall}, 32'h1F);
        tick();
        reset       = 1'b0;
        stallreq_ms = 1'b0;
        @(negedge clk);
        check("rst_pend_flush0", {31'd0, flush}, 32'd0);
        check("rst_pend_count", stall_cycles, 32'd0);
        tick();
        @(negedge clk);
        check("rst_pend_flush1", {31'd0, flush}, 32'd0);
        tick();
        @(negedge clk);
        check("rst_pend_flush2", {31'd0, flush}, 32'd0);
        tick();

        // Watchdog: 4 consecutive stalled cycles with TIMEOUT=4 sets the sticky flag.
        stallreq_fs = 1'b1;
        @(negedge clk);
        check("wd_c1", {31'd0, stall_timeout}, 32'd0);
        tick();
        tick();
        tick();
        @(negedge clk);
        check("wd_c4", {31'd0, stall_timeout}, 32'd0);
        tick();
        stallreq_fs = 1'b0;
        @(negedge clk);
        check("wd_c5_set", {31'd0, stall_timeout}, 32'd1);
        tick();
        tick();
        @(negedge clk);
        check("wd_sticky", {31'd0, stall_timeout}, 32'd1);
        check("wd_count", stall_cycles, 32'd4);
        tick();

        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("wd_cleared_by_reset", {31'd0, stall_timeout}, 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
